// File: rtl/sdram_init_seq_if.sv
// Command-bus bundle between the SDRAM power-up sequencer and the controller core.
// The sequencer drives the command lines and init_done; the core drives the enable.
interface sdram_init_seq_if;
    logic        sdram_en;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [11:0] sdram_addr;
    logic        init_done;

    modport master (
        input  sdram_en,
        output sdram_cs_n,
        output sdram_ras_n,
        output sdram_cas_n,
        output sdram_we_n,
        output sdram_ba,
        output sdram_addr,
        output init_done
    );

    modport slave (
        output sdram_en,
        input  sdram_cs_n,
        input  sdram_ras_n,
        input  sdram_cas_n,
        input  sdram_we_n,
        input  sdram_ba,
        input  sdram_addr,
        input  init_done
    );
endinterface

// File: rtl/sdram_init_seq.sv
// SDRAM power-up sequencer: NOP wait, precharge-all, two auto-refreshes, optional load-mode-register.
// Define SDRAM_INIT_MRS_EN to include the MRS/MRD_WAIT step; otherwise RFC2_WAIT goes straight to DONE.
module sdram_init_seq #(
    parameter int unsigned INIT_NOP_CYCLES = 10000,
    parameter int unsigned CMD_CYCLES      = 2,
    parameter int unsigned T_RP            = 3,
    parameter int unsigned T_RFC           = 8,
    parameter int unsigned T_MRD           = 2,
    parameter logic [11:0] MODE_REG        = 12'h033
) (
    input  logic             sdram_clk,
    input  logic             sdram_resetn,
    sdram_init_seq_if.master bus
);

    typedef enum logic [3:0] {
        IDLE,
        PWR_WAIT,
        PRE,
        RP_WAIT,
        REF1,
        RFC1_WAIT,
        REF2,
        RFC2_WAIT,
`ifdef SDRAM_INIT_MRS_EN
        MRS,
        MRD_WAIT,
`endif
        DONE
    } state_t;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000,
        CMD_REF = 3'b001,
        CMD_PRE = 3'b010,
        CMD_NOP = 3'b111
    } cmd_t;

    localparam logic [15:0] NOP_LOAD = 16'(INIT_NOP_CYCLES - 1);
    localparam logic [15:0] CMD_LOAD = 16'(CMD_CYCLES - 1);
    localparam logic [15:0] RP_LOAD  = 16'(T_RP - 1);
    localparam logic [15:0] RFC_LOAD = 16'(T_RFC - 1);
`ifdef SDRAM_INIT_MRS_EN
    localparam logic [15:0] MRD_LOAD = 16'(T_MRD - 1);
`else
    localparam logic [12:0] unused_mrs_params = {MODE_REG, 1'(T_MRD)};
`endif

    state_t      state;
    state_t      next_state;
    logic [15:0] cnt;
    logic [15:0] next_cnt;
    logic        en_q;
    logic        start;
    cmd_t        cmd_d;
    logic        cs_n_d;
    logic [11:0] addr_d;
    logic        done_d;

    assign start = bus.sdram_en & ~en_q;

    // Counter reload value is (duration - 1) so a state lasts exactly its duration.
    function automatic logic [15:0] load_for(state_t s);
        case (s)
            PWR_WAIT:             return NOP_LOAD;
            PRE, REF1, REF2:      return CMD_LOAD;
            RP_WAIT:              return RP_LOAD;
            RFC1_WAIT, RFC2_WAIT: return RFC_LOAD;
`ifdef SDRAM_INIT_MRS_EN
            MRS:                  return CMD_LOAD;
            MRD_WAIT:             return MRD_LOAD;
`endif
            default:              return 16'd0;
        endcase
    endfunction

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state <= IDLE;
            cnt   <= 16'd0;
            en_q  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            en_q  <= bus.sdram_en;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = (cnt == 16'd0) ? 16'd0 : cnt - 16'd1;
        if (state != IDLE && !bus.sdram_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      if (start)          next_state = PWR_WAIT;
                PWR_WAIT:  if (cnt == 16'd0)   next_state = PRE;
                PRE:       if (cnt == 16'd0)   next_state = RP_WAIT;
                RP_WAIT:   if (cnt == 16'd0)   next_state = REF1;
                REF1:      if (cnt == 16'd0)   next_state = RFC1_WAIT;
                RFC1_WAIT: if (cnt == 16'd0)   next_state = REF2;
                REF2:      if (cnt == 16'd0)   next_state = RFC2_WAIT;
`ifdef SDRAM_INIT_MRS_EN
                RFC2_WAIT: if (cnt == 16'd0)   next_state = MRS;
                MRS:       if (cnt == 16'd0)   next_state = MRD_WAIT;
                MRD_WAIT:  if (cnt == 16'd0)   next_state = DONE;
`else
                RFC2_WAIT: if (cnt == 16'd0)   next_state = DONE;
`endif
                DONE:                          next_state = DONE;
                default:                       next_state = IDLE;
            endcase
        end
        if (next_state != state) begin
            next_cnt = load_for(next_state);
        end
    end

    // Outputs are decoded from the next state so they appear registered, in step with the state.
    always_comb begin
        cmd_d  = CMD_NOP;
        cs_n_d = 1'b0;
        addr_d = 12'h000;
        done_d = 1'b0;
        case (next_state)
            IDLE: cs_n_d = 1'b1;
            PRE: begin
                cmd_d      = CMD_PRE;
                addr_d[10] = 1'b1;
            end
            REF1, REF2: cmd_d = CMD_REF;
`ifdef SDRAM_INIT_MRS_EN
            MRS: begin
                cmd_d  = CMD_MRS;
                addr_d = MODE_REG;
            end
`endif
            DONE: done_d = 1'b1;
            default: cmd_d = CMD_NOP;
        endcase
    end

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            bus.sdram_cs_n  <= 1'b1;
            bus.sdram_ras_n <= 1'b1;
            bus.sdram_cas_n <= 1'b1;
            bus.sdram_we_n  <= 1'b1;
            bus.sdram_ba    <= 2'b00;
            bus.sdram_addr  <= 12'h000;
            bus.init_done   <= 1'b0;
        end else begin
            bus.sdram_cs_n  <= cs_n_d;
            {bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} <= cmd_d;
            bus.sdram_ba    <= 2'b00;
            bus.sdram_addr  <= addr_d;
            bus.init_done   <= done_d;
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
`timescale 1ns/1ps
// Bench for sdram_init_seq: three instances with different timings checked every cycle
// against a schedule model built from segment durations; SDRAM_INIT_MRS_EN selects the MRS step.
module tb_sdram_init_seq;

    localparam int NOP_A = 10000, CMD_A = 2, RP_A = 3, RFC_A = 8, MRD_A = 2;
    localparam int NOP_B = 4,     CMD_B = 1, RP_B = 1, RFC_B = 2, MRD_B = 1;
    localparam int NOP_C = 1,     CMD_C = 1, RP_C = 1, RFC_C = 1, MRD_C = 1;
    localparam logic [11:0] MODE_A = 12'h033, MODE_B = 12'h033, MODE_C = 12'h5A5;

    localparam int LENS [3][5] = '{'{NOP_A, CMD_A, RP_A, RFC_A, MRD_A},
                                   '{NOP_B, CMD_B, RP_B, RFC_B, MRD_B},
                                   '{NOP_C, CMD_C, RP_C, RFC_C, MRD_C}};
    localparam logic [11:0] MODES [3] = '{MODE_A, MODE_B, MODE_C};

`ifdef SDRAM_INIT_MRS_EN
    localparam int NSEG = 9;
    localparam int EXP_DONE_A = 10030;
    localparam int EXP_DONE_B = 15;
    localparam int EXP_DONE_C = 10;
`else
    localparam int NSEG = 7;
    localparam int EXP_DONE_A = 10026;
    localparam int EXP_DONE_B = 13;
    localparam int EXP_DONE_C = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en_a = 1'b0;
    logic en_b = 1'b0;
    logic en_c = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   phase = 0;
    bit   rand_stop = 1'b0;
    bit   bc_checked = 1'b0;

    bit   active [3];
    int   t [3];
    bit   en_prev [3];
    bit   done_seen [3];
    int   dut_done_t [3];

    sdram_init_seq_if if_a ();
    sdram_init_seq_if if_b ();
    sdram_init_seq_if if_c ();

    assign if_a.sdram_en = en_a;
    assign if_b.sdram_en = en_b;
    assign if_c.sdram_en = en_c;

    sdram_init_seq #(.INIT_NOP_CYCLES(NOP_A), .CMD_CYCLES(CMD_A), .T_RP(RP_A), .T_RFC(RFC_A),
                     .T_MRD(MRD_A), .MODE_REG(MODE_A))
        dut_a (.sdram_clk(clk), .sdram_resetn(rst_n), .bus(if_a));
    sdram_init_seq #(.INIT_NOP_CYCLES(NOP_B), .CMD_CYCLES(CMD_B), .T_RP(RP_B), .T_RFC(RFC_B),
                     .T_MRD(MRD_B), .MODE_REG(MODE_B))
        dut_b (.sdram_clk(clk), .sdram_resetn(rst_n), .bus(if_b));
    sdram_init_seq #(.INIT_NOP_CYCLES(NOP_C), .CMD_CYCLES(CMD_C), .T_RP(RP_C), .T_RFC(RFC_C),
                     .T_MRD(MRD_C), .MODE_REG(MODE_C))
        dut_c (.sdram_clk(clk), .sdram_resetn(rst_n), .bus(if_c));

    logic [18:0] act_a, act_b, act_c;
    assign act_a = {if_a.sdram_cs_n, if_a.sdram_ras_n, if_a.sdram_cas_n, if_a.sdram_we_n,
                    if_a.sdram_ba, if_a.sdram_addr, if_a.init_done};
    assign act_b = {if_b.sdram_cs_n, if_b.sdram_ras_n, if_b.sdram_cas_n, if_b.sdram_we_n,
                    if_b.sdram_ba, if_b.sdram_addr, if_b.init_done};
    assign act_c = {if_c.sdram_cs_n, if_c.sdram_ras_n, if_c.sdram_cas_n, if_c.sdram_we_n,
                    if_c.sdram_ba, if_c.sdram_addr, if_c.init_done};

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    // Packed view: {cs_n, ras_n, cas_n, we_n, ba[1:0], addr[11:0], init_done}
    function automatic logic [18:0] mk(logic [2:0] cmd, logic [11:0] addr, logic cs_n, logic done);
        return {cs_n, cmd, 2'b00, addr, done};
    endfunction

    function automatic logic [18:0] get_act(int i);
        case (i)
            0:       return act_a;
            1:       return act_b;
            default: return act_c;
        endcase
    endfunction

    function automatic logic get_en(int i);
        case (i)
            0:       return en_a;
            1:       return en_b;
            default: return en_c;
        endcase
    endfunction

    // Bus contents on the t-th cycle after the start edge, from the ordered list of segment lengths.
    function automatic logic [18:0] sched(int i, int t_v);
        int lens [9];
        int acc;
        lens = '{LENS[i][0], LENS[i][1], LENS[i][2], LENS[i][1], LENS[i][3],
                 LENS[i][1], LENS[i][3], LENS[i][1], LENS[i][4]};
        acc = 0;
        for (int s = 0; s < NSEG; s++) begin
            if (t_v <= acc + lens[s]) begin
                case (s)
                    1:       return mk(3'b010, 12'h400, 1'b0, 1'b0);
                    3, 5:    return mk(3'b001, 12'h000, 1'b0, 1'b0);
                    7:       return mk(3'b000, MODES[i], 1'b0, 1'b0);
                    default: return mk(3'b111, 12'h000, 1'b0, 1'b0);
                endcase
            end
            acc = acc + lens[s];
        end
        return mk(3'b111, 12'h000, 1'b0, 1'b1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: actual=%h required=%h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst_v, input logic en_v);
        rst_n = rst_v;
        en_a  = en_v;
    endtask

    task automatic waitDone(input int i, input int budget, input string name);
        for (int n = 0; n < budget && !done_seen[i]; n++) @(negedge clk);
        checkOutput(name, {31'd0, done_seen[i]}, 32'd1);
    endtask

    task automatic waitModelT(input int target, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < budget && !hit; n++) begin
            @(negedge clk);
            hit = active[0] && (t[0] == target);
        end
        checkOutput(name, {31'd0, hit}, 32'd1);
    endtask

    // Reference: an instance is active from a sampled enable edge until enable is sampled low.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                active[i]  <= 1'b0;
                t[i]       <= 0;
                en_prev[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (active[i] && !get_en(i)) begin
                    active[i] <= 1'b0;
                end else if (active[i]) begin
                    t[i] <= t[i] + 1;
                end else if (get_en(i) && !en_prev[i]) begin
                    active[i] <= 1'b1;
                    t[i]      <= 1;
                end
                en_prev[i] <= get_en(i);
            end
        end
    end

    always @(negedge clk) begin : compare_proc
        logic [18:0] a_v;
        logic [18:0] e_v;
        string       nm;
        for (int i = 0; i < 3; i++) begin
            a_v = get_act(i);
            e_v = active[i] ? sched(i, t[i]) : mk(3'b111, 12'h000, 1'b1, 1'b0);
            nm  = (i == 0) ? "bus_a" : (i == 1) ? "bus_b" : "bus_c";
            checkOutput(nm, {13'd0, a_v}, {13'd0, e_v});
            if (!active[i]) begin
                done_seen[i] = 1'b0;
            end else if (!done_seen[i] && a_v[0] === 1'b1) begin
                done_seen[i]  = 1'b1;
                dut_done_t[i] = t[i];
            end
        end
    end

    initial begin : bc_driver
        wait (phase == 1);
        @(negedge clk);
        en_b = 1'b1;
        @(negedge clk);
        en_c = 1'b1;
        for (int n = 0; n < 100 && !(done_seen[1] && done_seen[2]); n++) @(negedge clk);
        checkOutput("done_t_b", dut_done_t[1], EXP_DONE_B);
        checkOutput("done_t_c", dut_done_t[2], EXP_DONE_C);
        bc_checked = 1'b1;
        while (!rand_stop) begin
            @(negedge clk);
            if ($urandom_range(0, 15) == 0) en_b = ~en_b;
            if ($urandom_range(0, 11) == 0) en_c = ~en_c;
        end
    end

    initial begin : main_seq
        for (int i = 0; i < 3; i++) begin
            done_seen[i]  = 1'b0;
            dut_done_t[i] = -1;
        end
        applyStimulus(1'b0, 1'b0);

        checkOutput("pin_a_last_nop", {13'd0, sched(0, 10000)}, {13'd0, mk(3'b111, 12'h000, 1'b0, 1'b0)});
        checkOutput("pin_a_pre",      {13'd0, sched(0, 10001)}, {13'd0, mk(3'b010, 12'h400, 1'b0, 1'b0)});
        checkOutput("pin_a_ref1",     {13'd0, sched(0, 10006)}, {13'd0, mk(3'b001, 12'h000, 1'b0, 1'b0)});
        checkOutput("pin_a_ref2",     {13'd0, sched(0, 10016)}, {13'd0, mk(3'b001, 12'h000, 1'b0, 1'b0)});
        checkOutput("pin_a_pre_done", {13'd0, sched(0, EXP_DONE_A - 1)}, {13'd0, mk(3'b111, 12'h000, 1'b0, 1'b0)});
        checkOutput("pin_a_done",     {13'd0, sched(0, EXP_DONE_A)}, {13'd0, mk(3'b111, 12'h000, 1'b0, 1'b1)});
        checkOutput("pin_b_pre",      {13'd0, sched(1, 5)}, {13'd0, mk(3'b010, 12'h400, 1'b0, 1'b0)});
        checkOutput("pin_c_ref2",     {13'd0, sched(2, 6)}, {13'd0, mk(3'b001, 12'h000, 1'b0, 1'b0)});
`ifdef SDRAM_INIT_MRS_EN
        checkOutput("pin_a_mrs",      {13'd0, sched(0, 10026)}, {13'd0, mk(3'b000, 12'h033, 1'b0, 1'b0)});
        checkOutput("pin_c_mrs",      {13'd0, sched(2, 8)}, {13'd0, mk(3'b000, 12'h5A5, 1'b0, 1'b0)});
`else
        checkOutput("pin_a_no_mrs",   {13'd0, sched(0, 10026)}, {13'd0, mk(3'b111, 12'h000, 1'b0, 1'b1)});
        checkOutput("pin_b_no_mrs",   {13'd0, sched(1, 12)}, {13'd0, mk(3'b111, 12'h000, 1'b0, 1'b0)});
`endif

        // Enable wiggles while reset is held must not issue anything.
        repeat (5) begin
            @(negedge clk);
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0);
        repeat (4 + $urandom_range(0, 3)) @(negedge clk);
        checkOutput("idle_cs_n", {31'd0, if_a.sdram_cs_n}, 32'd1);
        phase = 1;

        // Clean full sequence on instance A.
        repeat ($urandom_range(1, 5)) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        waitDone(0, 10100, "done_seen_a1");
        checkOutput("done_t_a1", dut_done_t[0], EXP_DONE_A);
        repeat ($urandom_range(2, 8)) @(negedge clk);
        checkOutput("done_hold_a", {31'd0, if_a.init_done}, 32'd1);

        // Drop the enable in DONE: init_done falls the next cycle.
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("done_fall_a", {31'd0, if_a.init_done}, 32'd0);
        checkOutput("drop_cs_n_a", {31'd0, if_a.sdram_cs_n}, 32'd1);

        // Abort somewhere in RFC1_WAIT, then a full restart.
        applyStimulus(1'b1, 1'b1);
        waitModelT(NOP_A + 2 * CMD_A + RP_A + 1 + $urandom_range(0, RFC_A - 1), 10100, "reach_rfc1_a");
        applyStimulus(1'b1, 1'b0);
        @(negedge clk);
        checkOutput("abort_cs_n_a", {31'd0, if_a.sdram_cs_n}, 32'd1);
        checkOutput("abort_ras_n_a", {31'd0, if_a.sdram_ras_n}, 32'd1);
        repeat ($urandom_range(0, 4)) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        waitDone(0, 10100, "done_seen_a2");
        checkOutput("done_t_a2", dut_done_t[0], EXP_DONE_A);

        // Asynchronous reset in the middle of PRE, enable held high through release.
        applyStimulus(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        waitModelT(NOP_A + 1, 10100, "reach_pre_a");
        @(posedge clk);
        #2;
        checkOutput("pre_ras_n_a", {31'd0, if_a.sdram_ras_n}, 32'd0);
        applyStimulus(1'b0, 1'b1);
        #1;
        checkOutput("rst_ras_n_a", {31'd0, if_a.sdram_ras_n}, 32'd1);
        checkOutput("rst_we_n_a", {31'd0, if_a.sdram_we_n}, 32'd1);
        checkOutput("rst_cs_n_a", {31'd0, if_a.sdram_cs_n}, 32'd1);
        checkOutput("rst_addr_a", {20'd0, if_a.sdram_addr}, 32'd0);
        repeat (3) @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        waitDone(0, 10100, "done_seen_a3");
        checkOutput("done_t_a3", dut_done_t[0], EXP_DONE_A);

        rand_stop = 1'b1;
        checkOutput("bc_checked", {31'd0, bc_checked}, 32'd1);
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
